ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the two ports of the 16x16 dual-port RAM among NREQ requesters.
- Grants up to two requests per cycle, one to port A and one to port B, with round-robin fairness.
- Suppresses same-address write/write collisions and returns read data to the originating requester through a registered response.
- Sits between the requester fabric and the RAM instance; drives all RAM port signals.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 4, RAM address width.
- DW, 16, RAM data width.

Ports:
- clk  in  1  system clock; RAM writes on posedge, RAM reads on negedge.
- rst_n  in  1  synchronous reset, active-low, sampled on posedge clk.
- req_valid  in  NREQ  per-requester request valid.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_ready  out  NREQ  combinational grant; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  registered one-cycle read-response strobe.
- rsp_data  out  DW  registered read data, valid when any rsp_valid bit is set. Both ports may respond in one cycle; see the rsp_data_b port.
- rsp_data_b  out  DW  second response data, carried for the port-B grant.
- rsp_port  out  NREQ  per requester: 0 = take rsp_data, 1 = take rsp_data_b.
- ram_we_a, ram_we_b  out  1  RAM write enables.
- ram_waddr_a, ram_waddr_b  out  AW  RAM write addresses.
- ram_wdata_a, ram_wdata_b  out  DW  RAM write data.
- ram_raddr_a, ram_raddr_b  out  AW  RAM read addresses.
- ram_rdata_a, ram_rdata_b  in  DW  RAM read data, updated on negedge clk.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - rr_ptr = 0; rsp_valid = 0; rsp_port = 0; rsp_data = 0; rsp_data_b = 0.
  - Internal pending-read tags are cleared, so reads granted in the reset cycle produce no response.
  - While rst_n = 0, req_ready = 0 and ram_we_a = ram_we_b = 0.
- Grant selection (combinational, each cycle):
  - Scan requesters from rr_ptr upward, modulo NREQ.
  - The first valid requester gets port A; the next eligible valid requester gets port B.
  - Eligibility for port B: if both port-A and candidate requests are writes with equal addresses, the candidate is ineligible and scanning continues. Requests skipped this way stay pending with ready = 0.
  - Read/read and read/write to the same address are both allowed.
  - Fewer than two valid requesters leaves the unused port idle: we = 0, addresses = 0.
- RAM drive:
  - A granted write drives ram_we_x = 1 with its address and data.
  - A granted read drives ram_raddr_x. The read address is held through the negedge of the same cycle.
- Read response:
  - The RAM captures data at the negedge of the grant cycle N.
  - At posedge end of cycle N, the block registers ram_rdata_a into rsp_data and ram_rdata_b into rsp_data_b, and sets rsp_valid[i] and rsp_port[i] for each granted reader.
  - Latency is exactly 1 cycle; rsp_valid is high for cycle N+1 only.
  - A read and a write to the same address in the same cycle: the read returns the OLD value, because the negedge read precedes the posedge write.
- Round-robin:
  - After any grant, rr_ptr = (index of last granted requester, port B if granted else port A) + 1, modulo NREQ.
  - With no grant, rr_ptr holds.
- Starvation bound: a continuously valid requester is granted within ceil(NREQ/2) cycles, except for collision skips.
- Writes require no response. A write is complete at the posedge ending its grant cycle.
- Reset asserted mid-operation: reads granted in that cycle give no response, and all outputs take reset values on the next posedge.

Test Plan:
1. Reset, then req0 reads addr 3 with RAM preloaded 0xBEEF -> req_ready[0] = 1 in cycle N; rsp_valid[0] = 1 in N+1 with rsp_port[0] = 0 and rsp_data = 0xBEEF; idle in N+2.
2. All 4 requesters valid, reads, held high for 4 cycles from rr_ptr = 0 -> grants {0,1}, {2,3}, {0,1}, {2,3}; rr_ptr sequence 0, 2, 0, 2.
3. req0 and req1 both write addr 5 (0x1111 and 0x2222), req2 idle -> req0 granted on port A, req1 ready = 0. Next cycle req1 granted; a subsequent read of addr 5 returns 0x2222.
4. Same cycle: req0 writes addr 7 = 0xAAAA, req1 reads addr 7 (old value 0x5555) -> rsp_data_b = 0x5555 with rsp_port[1] = 1; a read of addr 7 the next cycle returns 0xAAAA.
5. req2 reads and rst_n is driven low in the grant cycle -> no rsp_valid afterwards; all outputs zero; rr_ptr = 0.
6. Only req3 valid, alternating write/read of addr 15 with 0x0F0F -> port A used every cycle, port B idle (ram_we_b = 0); read response 0x0F0F one cycle after the read grant.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares the two ports (A and B) of a dual-port RAM among NREQ requesters.
// Up to two requests are granted per cycle. The first valid requester found
// from the round-robin pointer gets port A. The next eligible one gets port B.
// Read data returns to the originating requester one cycle after the grant.
//
// The RAM writes on posedge clk and reads on negedge clk. A read therefore
// sees the contents from before any write granted in the same cycle.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset, sampled on posedge clk
//   req_valid    per-requester request valid
//   req_we       per-requester direction (1 = write, 0 = read)
//   req_addr     flattened addresses, requester i at [i*AW +: AW]
//   req_wdata    flattened write data, requester i at [i*DW +: DW]
//   req_ready    combinational grant; a transfer is valid & ready
//   rsp_valid    registered one-cycle read-response strobe per requester
//   rsp_data     registered read data from port A
//   rsp_data_b   registered read data from port B
//   rsp_port     per requester: 0 = take rsp_data, 1 = take rsp_data_b
//   ram_*_a/b    RAM port drive (write enable/address/data, read address)
//   ram_rdata_*  RAM read data, updated on negedge clk
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,

    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic [DW-1:0]     rsp_data_b,
    output logic [NREQ-1:0]   rsp_port,

    output logic              ram_we_a,
    output logic [AW-1:0]     ram_waddr_a,
    output logic [DW-1:0]     ram_wdata_a,
    output logic [AW-1:0]     ram_raddr_a,
    input  logic [DW-1:0]     ram_rdata_a,

    output logic              ram_we_b,
    output logic [AW-1:0]     ram_waddr_b,
    output logic [DW-1:0]     ram_wdata_b,
    output logic [AW-1:0]     ram_raddr_b,
    input  logic [DW-1:0]     ram_rdata_b
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IW-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [NREQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [NREQ-1:0] rsp_port_q,   rsp_port_d;
    logic [DW-1:0]   rsp_data_q,   rsp_data_d;
    logic [DW-1:0]   rsp_data_b_q, rsp_data_b_d;

    // ------------------------------------------------------------------------
    // Unflatten the request buses so the grant logic can index per requester
    // ------------------------------------------------------------------------
    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
    end

    // ------------------------------------------------------------------------
    // Grant selection
    //
    // Scan from rr_ptr upward, modulo NREQ. The first valid requester takes
    // port A. Port B goes to the next valid requester that does not collide
    // with port A. A collision is two writes to the same address; such a
    // candidate is skipped and keeps ready = 0 this cycle. Nothing is granted
    // while reset is asserted.
    // ------------------------------------------------------------------------
    logic          gnt_a_vld, gnt_b_vld;
    logic [IW-1:0] gnt_a_idx, gnt_b_idx;

    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        logic          collide;

        gnt_a_vld = 1'b0;
        gnt_b_vld = 1'b0;
        gnt_a_idx = '0;
        gnt_b_idx = '0;
        idx       = 0;
        cand      = '0;
        collide   = 1'b0;

        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);

            if (rst_n && req_valid[cand]) begin
                if (!gnt_a_vld) begin
                    gnt_a_vld = 1'b1;
                    gnt_a_idx = cand;
                end else if (!gnt_b_vld) begin
                    collide = req_we[gnt_a_idx] && req_we[cand] &&
                              (addr_arr[gnt_a_idx] == addr_arr[cand]);
                    if (!collide) begin
                        gnt_b_vld = 1'b1;
                        gnt_b_idx = cand;
                    end
                end
            end
        end
    end

    // Decoded per-port direction of the granted request
    logic wr_a, rd_a, wr_b, rd_b;

    assign wr_a = gnt_a_vld &&  req_we[gnt_a_idx];
    assign rd_a = gnt_a_vld && !req_we[gnt_a_idx];
    assign wr_b = gnt_b_vld &&  req_we[gnt_b_idx];
    assign rd_b = gnt_b_vld && !req_we[gnt_b_idx];

    always_comb begin
        req_ready = '0;
        if (gnt_a_vld) begin
            req_ready[gnt_a_idx] = 1'b1;
        end
        if (gnt_b_vld) begin
            req_ready[gnt_b_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // RAM drive. Fields that the granted operation does not use are zero, so
    // an idle port shows we = 0 and all-zero addresses.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_we_a    = wr_a;
        ram_waddr_a = wr_a ? addr_arr[gnt_a_idx]  : '0;
        ram_wdata_a = wr_a ? wdata_arr[gnt_a_idx] : '0;
        ram_raddr_a = rd_a ? addr_arr[gnt_a_idx]  : '0;

        ram_we_b    = wr_b;
        ram_waddr_b = wr_b ? addr_arr[gnt_b_idx]  : '0;
        ram_wdata_b = wr_b ? wdata_arr[gnt_b_idx] : '0;
        ram_raddr_b = rd_b ? addr_arr[gnt_b_idx]  : '0;
    end

    // ------------------------------------------------------------------------
    // Round-robin pointer: one past the last granted requester. That is the
    // port-B grant if present, else the port-A grant. It holds when idle.
    // ------------------------------------------------------------------------
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
        if (int'(cur) == NREQ - 1) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_b_vld) begin
            rr_ptr_d = next_idx(gnt_b_idx);
        end else if (gnt_a_vld) begin
            rr_ptr_d = next_idx(gnt_a_idx);
        end
    end

    // ------------------------------------------------------------------------
    // Read response. The RAM has already placed read data on ram_rdata_x at
    // the negedge of the grant cycle. That data is captured at the posedge
    // ending the cycle and tagged to the requester that was granted. Each
    // data register loads only when its port carried a read, so a response
    // on one port does not disturb the other port's data.
    // ------------------------------------------------------------------------
    always_comb begin
        rsp_valid_d  = '0;
        rsp_port_d   = '0;
        rsp_data_d   = rsp_data_q;
        rsp_data_b_d = rsp_data_b_q;

        if (rd_a) begin
            rsp_valid_d[gnt_a_idx] = 1'b1;
            rsp_data_d             = ram_rdata_a;
        end
        if (rd_b) begin
            rsp_valid_d[gnt_b_idx] = 1'b1;
            rsp_port_d[gnt_b_idx]  = 1'b1;
            rsp_data_b_d           = ram_rdata_b;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // All registers then sample their inputs at the same posedge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_port_q   <= '0;
            rsp_data_q   <= '0;
            rsp_data_b_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            rsp_data_q   <= rsp_data_d;
            rsp_data_b_q <= rsp_data_b_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_port   = rsp_port_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_data_b = rsp_data_b_q;

endmodule
